// File: rtl/sram_access_ctrl.sv
// Sequencer/arbiter for the single shared SRAM port: row-cache read bursts and single
// output-word writes, driving the address calculator and a sticky wait-timeout flag.
module sram_access_ctrl #(
  parameter int unsigned WIDTH_BITS = 13,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH_BITS-1:0] image_width,
  input  logic                  row_req,
  input  logic                  out_req,
  input  logic                  sram_busy,
  output logic                  row_wr_en,
  output logic                  row_done,
  output logic                  out_ack,
  output logic                  sram_read_en,
  output logic                  sram_write_en,
  output logic                  calc_clear,
  output logic                  calc_mode,
  output logic                  calc_enable,
  output logic                  ctrl_busy,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRdIssue,
    StRdWait,
    StWrIssue,
    StWrWait,
    StRowEnd
  } state_e;

  // Last timer value before expiry: the TIMEOUT-th wait cycle abandons the access.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [WIDTH_BITS-1:0] row_cnt_q, row_cnt_d;
  logic [WIDTH_BITS-1:0] row_limit_q, row_limit_d;
  logic [WIDTH_BITS-1:0] row_cnt_inc;
  logic [7:0]            timer_q, timer_d;
  logic                  rr_q, rr_d;
  logic                  mode_q, mode_d;
  logic                  err_q, err_d;
  logic                  row_pend_q, row_pend_d;
  logic                  out_pend_q, out_pend_d;
  logic                  row_want, out_want, grant_row;

  // A request level still high in the cycle of its own done/ack is a fresh request,
  // so it is captured there rather than re-sampled later in IDLE.
  assign row_want    = row_req | row_pend_q;
  assign out_want    = out_req | out_pend_q;
  assign grant_row   = row_want & (~out_want | ~rr_q);
  assign row_cnt_inc = row_cnt_q + WIDTH_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      row_cnt_q   <= '0;
      row_limit_q <= '0;
      timer_q     <= '0;
      rr_q        <= 1'b0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      row_pend_q  <= 1'b0;
      out_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      row_limit_q <= row_limit_d;
      timer_q     <= timer_d;
      rr_q        <= rr_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      row_pend_q  <= row_pend_d;
      out_pend_q  <= out_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    row_limit_d = row_limit_q;
    timer_d     = timer_q;
    rr_d        = rr_q;
    mode_d      = mode_q;
    err_d       = err_q;
    row_pend_d  = row_pend_q;
    out_pend_d  = out_pend_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClr;
        end else if (grant_row) begin
          row_limit_d = image_width;
          row_cnt_d   = '0;
          mode_d      = 1'b1;
          row_pend_d  = 1'b0;
          state_d     = (image_width == '0) ? StRowEnd : StRdIssue;
        end else if (out_want) begin
          mode_d     = 1'b0;
          out_pend_d = 1'b0;
          state_d    = StWrIssue;
        end
      end
      StClr: state_d = StIdle;
      StRdIssue: begin
        timer_d = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (!sram_busy) begin
          row_cnt_d = row_cnt_inc;
          state_d   = (row_cnt_inc == row_limit_q) ? StRowEnd : StRdIssue;
        end else if (timer_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StRowEnd: begin
        rr_d       = ~rr_q;
        row_pend_d = row_req;
        state_d    = StIdle;
      end
      StWrIssue: begin
        timer_d = '0;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (!sram_busy) begin
          rr_d       = ~rr_q;
          out_pend_d = out_req;
          state_d    = StIdle;
        end else if (timer_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while rst is high so a mid-burst reset emits no pulses.
  always_comb begin
    row_wr_en     = 1'b0;
    row_done      = 1'b0;
    out_ack       = 1'b0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    calc_clear    = 1'b0;
    calc_enable   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StClr:     calc_clear = 1'b1;
        StRdIssue: sram_read_en = 1'b1;
        StRdWait: begin
          if (!sram_busy) begin
            row_wr_en   = 1'b1;
            calc_enable = 1'b1;
          end
        end
        StRowEnd:  row_done = 1'b1;
        StWrIssue: sram_write_en = 1'b1;
        StWrWait: begin
          if (!sram_busy) begin
            out_ack     = 1'b1;
            calc_enable = 1'b1;
          end
        end
        default: ;
      endcase
    end
    calc_mode   = mode_q & ~rst;
    ctrl_busy   = (state_q != StIdle) & ~rst;
    timeout_err = err_q & ~rst;
  end

`ifndef SYNTHESIS
  a_enable_excl: assert property (@(posedge clk) disable iff (rst)
    !(calc_enable && (calc_clear || state_q == StIdle)));
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    !(sram_read_en && sram_write_en));
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: cycle-exact output vectors per scenario.
module tb_sram_access_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [12:0] image_width;
  logic        row_req;
  logic        out_req;
  logic        sram_busy;
  logic        row_wr_en, row_done, out_ack, sram_read_en, sram_write_en;
  logic        calc_clear, calc_mode, calc_enable, ctrl_busy, timeout_err;
  logic [9:0]  outs;

  int          n_checks;
  int          n_errors;
  int          n_rd;
  int          n_rwe;
  int          rows_seen, rows_wanted;
  int          writes_seen, writes_wanted;
  logic [31:0] seq_code;

  sram_access_ctrl #(
    .WIDTH_BITS(13),
    .TIMEOUT   (255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .image_width  (image_width),
    .row_req      (row_req),
    .out_req      (out_req),
    .sram_busy    (sram_busy),
    .row_wr_en    (row_wr_en),
    .row_done     (row_done),
    .out_ack      (out_ack),
    .sram_read_en (sram_read_en),
    .sram_write_en(sram_write_en),
    .calc_clear   (calc_clear),
    .calc_mode    (calc_mode),
    .calc_enable  (calc_enable),
    .ctrl_busy    (ctrl_busy),
    .timeout_err  (timeout_err)
  );

  // Bit order: rwe done ack rd wr clr mode en busy err
  assign outs = {row_wr_en, row_done, out_ack, sram_read_en, sram_write_en,
                 calc_clear, calc_mode, calc_enable, ctrl_busy, timeout_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Samples mid-cycle, models requesters dropping in their own done/ack cycle.
  task automatic step(input bit chk, input string tag, input logic [9:0] exp);
    @(negedge clk);
    if (chk) check_eq(tag, 32'(outs), 32'(exp));
    if (sram_read_en) n_rd++;
    if (row_wr_en) n_rwe++;
    if (row_done) begin
      rows_seen++;
      seq_code = {seq_code[23:0], 8'h52};
      if (rows_seen == rows_wanted) row_req = 1'b0;
    end
    if (out_ack) begin
      writes_seen++;
      seq_code = {seq_code[23:0], 8'h57};
      if (writes_seen == writes_wanted) out_req = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    start         = 1'b0;
    row_req       = 1'b0;
    out_req       = 1'b0;
    sram_busy     = 1'b0;
    image_width   = '0;
    rows_seen     = 0;
    rows_wanted   = 0;
    writes_seen   = 0;
    writes_wanted = 0;
    seq_code      = '0;
    n_rd          = 0;
    n_rwe         = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state and frame-start clear
    do_reset();
    step(1, "reset_outs", 10'h000);
    start = 1'b1;
    step(1, "t1_start_cyc", 10'h000);
    start = 1'b0;
    step(1, "t1_clr", 10'h012);
    step(1, "t1_after", 10'h000);

    // start wins over a simultaneous row request
    do_reset();
    start       = 1'b1;
    row_req     = 1'b1;
    rows_wanted = 1;
    step(1, "tp_start", 10'h000);
    start = 1'b0;
    step(1, "tp_clr", 10'h012);
    step(1, "tp_grant", 10'h000);
    step(1, "tp_done", 10'h10A);
    step(1, "tp_idle", 10'h008);

    // Row burst of 4 words, SRAM never busy
    do_reset();
    image_width = 13'd4;
    row_req     = 1'b1;
    rows_wanted = 1;
    step(1, "t2_grant", 10'h000);
    for (int i = 0; i < 4; i++) begin
      step(1, $sformatf("t2_rd%0d", i), 10'h04A);
      step(1, $sformatf("t2_wait%0d", i), 10'h20E);
    end
    step(1, "t2_done", 10'h10A);
    step(1, "t2_idle", 10'h008);
    check_eq("t2_reads", n_rd, 4);

    // Single write with 3 busy cycles; start mid-service is ignored
    do_reset();
    out_req       = 1'b1;
    writes_wanted = 1;
    step(1, "t3_grant", 10'h000);
    step(1, "t3_wr", 10'h022);
    sram_busy = 1'b1;
    step(1, "t3_busy0", 10'h002);
    start = 1'b1;
    step(1, "t3_busy1", 10'h002);
    start = 1'b0;
    step(1, "t3_busy2", 10'h002);
    sram_busy = 1'b0;
    step(1, "t3_ack", 10'h086);
    step(1, "t3_idle", 10'h000);

    // Zero-width row: done with no SRAM access
    do_reset();
    row_req     = 1'b1;
    rows_wanted = 1;
    step(1, "t5_grant", 10'h000);
    step(1, "t5_done", 10'h10A);
    step(1, "t5_idle", 10'h008);
    check_eq("t5_reads", n_rd, 0);

    // Both requesters held: round-robin R W R W
    do_reset();
    image_width   = 13'd2;
    row_req       = 1'b1;
    out_req       = 1'b1;
    rows_wanted   = 2;
    writes_wanted = 2;
    for (int i = 0; i < 60 && !(rows_seen == 2 && writes_seen == 2); i++) step(0, "", 10'h000);
    check_eq("t4_order", seq_code, 32'h52575257);
    check_eq("t4_reads", n_rd, 4);
    step(1, "t4_idle0", 10'h000);
    step(1, "t4_idle1", 10'h000);

    // Busy stuck high: timeout on the 255th wait cycle, sticky flag
    do_reset();
    image_width = 13'd4;
    row_req     = 1'b1;
    sram_busy   = 1'b1;
    step(1, "t6_grant", 10'h000);
    step(1, "t6_rd", 10'h04A);
    row_req = 1'b0;
    step(1, "t6_wait_first", 10'h00A);
    for (int i = 0; i < 253; i++) step(0, "", 10'h000);
    step(1, "t6_wait_last", 10'h00A);
    step(1, "t6_err", 10'h009);
    sram_busy = 1'b0;
    for (int i = 0; i < 3; i++) step(1, $sformatf("t6_sticky%0d", i), 10'h009);
    check_eq("t6_no_rwe", n_rwe, 0);
    do_reset();
    step(1, "t6_cleared", 10'h000);

    // Reset in the middle of a burst
    do_reset();
    image_width = 13'd4;
    row_req     = 1'b1;
    step(1, "t7_grant", 10'h000);
    step(1, "t7_rd", 10'h04A);
    step(1, "t7_wait", 10'h20E);
    rst = 1'b1;
    step(1, "t7_rst_cyc", 10'h000);
    rst = 1'b0;
    step(1, "t7_after_rst", 10'h000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
